// File: rtl/alu_control_seq_pkg.sv
// Shared encodings for the ALU control sequencer: ALUOp classes, operation codes,
// execute-unit selects, funct7 patterns and the decoder result record.
package alu_control_seq_pkg;

    localparam logic [2:0] ALUOP_R   = 3'b000;
    localparam logic [2:0] ALUOP_I   = 3'b001;
    localparam logic [2:0] ALUOP_LUI = 3'b010;
    localparam logic [2:0] ALUOP_BR  = 3'b011;
    localparam logic [2:0] ALUOP_MEM = 3'b100;

    // Codes 0-5 match the old single-cycle ALU so existing execute logic keeps working.
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd2;
    localparam logic [3:0] OP_SLL  = 4'd3;
    localparam logic [3:0] OP_SRL  = 4'd4;
    localparam logic [3:0] OP_LUI  = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_MULH = 4'd12;
    localparam logic [3:0] OP_DIV  = 4'd13;
    localparam logic [3:0] OP_DIVU = 4'd14;
    localparam logic [3:0] OP_REM  = 4'd15;

    localparam logic [1:0] UNIT_ALU = 2'd0;
    localparam logic [1:0] UNIT_MUL = 2'd1;
    localparam logic [1:0] UNIT_DIV = 2'd2;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    typedef struct packed {
        logic [3:0] op;
        logic [1:0] unit;
        logic       illegal;
    } decode_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Base-funct7 arithmetic/logic op for a funct3 value, shared by R and I forms.
    function automatic logic [3:0] base_op(input logic [2:0] f3);
        logic [3:0] op;
        case (f3)
            3'b000:  op = OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_control_seq_if.sv
// Handshake and selector bundle between decode, the ALU control sequencer and execute.
interface alu_control_seq_if #(
    parameter int OP_W = 4
);
    logic            flush_i;
    logic            valid_i;
    logic            ready_o;
    logic [6:0]      funct7_i;
    logic [2:0]      alu_op_i;
    logic [2:0]      funct3_i;
    logic            valid_o;
    logic            ready_i;
    logic [OP_W-1:0] alu_operation_o;
    logic [1:0]      unit_sel_o;
    logic            illegal_o;
    logic            busy_o;

    modport master (
        output flush_i, valid_i, funct7_i, alu_op_i, funct3_i, ready_i,
        input  ready_o, valid_o, alu_operation_o, unit_sel_o, illegal_o, busy_o
    );

    modport slave (
        input  flush_i, valid_i, funct7_i, alu_op_i, funct3_i, ready_i,
        output ready_o, valid_o, alu_operation_o, unit_sel_o, illegal_o, busy_o
    );
endinterface

// File: rtl/alu_control_seq_decode.sv
// Purely combinational selector decode: {funct7, ALUOp, funct3} -> op code, unit, illegal.
module alu_control_seq_decode
    import alu_control_seq_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [6:0] funct7_i,
    input  logic [2:0] alu_op_i,
    input  logic [2:0] funct3_i,
    output decode_t    dec_o
);

    // Start from the illegal result; every legal path overwrites all three fields.
    always_comb begin
        dec_o = '{op: OP_ADD, unit: UNIT_ALU, illegal: 1'b1};
        case (alu_op_i)
            ALUOP_R: begin
                if (funct7_i == F7_BASE) begin
                    dec_o = '{op: base_op(funct3_i), unit: UNIT_ALU, illegal: 1'b0};
                end else if (funct7_i == F7_ALT) begin
                    if (funct3_i == 3'b000) begin
                        dec_o = '{op: OP_SUB, unit: UNIT_ALU, illegal: 1'b0};
                    end else if (funct3_i == 3'b101) begin
                        dec_o = '{op: OP_SRA, unit: UNIT_ALU, illegal: 1'b0};
                    end
                end else if (ENABLE_M && (funct7_i == F7_MULDIV)) begin
                    case (funct3_i)
                        3'b000:  dec_o = '{op: OP_MUL,  unit: UNIT_MUL, illegal: 1'b0};
                        3'b001:  dec_o = '{op: OP_MULH, unit: UNIT_MUL, illegal: 1'b0};
                        3'b100:  dec_o = '{op: OP_DIV,  unit: UNIT_DIV, illegal: 1'b0};
                        3'b101:  dec_o = '{op: OP_DIVU, unit: UNIT_DIV, illegal: 1'b0};
                        3'b110:  dec_o = '{op: OP_REM,  unit: UNIT_DIV, illegal: 1'b0};
                        default: ;
                    endcase
                end
            end
            ALUOP_I: begin
                // Immediate shifts carry their variant in funct7; everything else ignores it.
                case (funct3_i)
                    3'b001: begin
                        if (funct7_i == F7_BASE) begin
                            dec_o = '{op: OP_SLL, unit: UNIT_ALU, illegal: 1'b0};
                        end
                    end
                    3'b101: begin
                        if (funct7_i == F7_BASE) begin
                            dec_o = '{op: OP_SRL, unit: UNIT_ALU, illegal: 1'b0};
                        end else if (funct7_i == F7_ALT) begin
                            dec_o = '{op: OP_SRA, unit: UNIT_ALU, illegal: 1'b0};
                        end
                    end
                    default: dec_o = '{op: base_op(funct3_i), unit: UNIT_ALU, illegal: 1'b0};
                endcase
            end
            ALUOP_LUI: dec_o = '{op: OP_LUI, unit: UNIT_ALU, illegal: 1'b0};
            ALUOP_BR:  dec_o = '{op: OP_SUB, unit: UNIT_ALU, illegal: 1'b0};
            ALUOP_MEM: dec_o = '{op: OP_ADD, unit: UNIT_ALU, illegal: 1'b0};
            default:   ;
        endcase
    end

endmodule

// File: rtl/alu_control_seq.sv
// Registered, handshaked ALU control: decodes the selector, then holds the result in
// IDLE/WAIT/OUT so multi-cycle MUL/DIV ops present their result after their latency.
module alu_control_seq
    import alu_control_seq_pkg::*;
#(
    parameter int OP_W     = 4,
    parameter bit ENABLE_M = 1'b1,
    parameter int MUL_LAT  = 3,
    parameter int DIV_LAT  = 32
) (
    input logic              clk,
    input logic              reset,
    alu_control_seq_if.slave bus
);

    localparam int CNT_W = $clog2(max_int(MUL_LAT, DIV_LAT) + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    decode_t          res_q, res_d;
    decode_t          dec;
    logic             ready;
    logic             accept;

    alu_control_seq_decode #(
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .funct7_i (bus.funct7_i),
        .alu_op_i (bus.alu_op_i),
        .funct3_i (bus.funct3_i),
        .dec_o    (dec)
    );

    // A flush must never coincide with an accept, so it gates ready directly.
    assign ready  = !bus.flush_i &&
                    ((state_q == ST_IDLE) || ((state_q == ST_OUT) && bus.ready_i));
    assign accept = bus.valid_i && ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        if (bus.flush_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (accept) begin
            res_d = dec;
            // The counter is loaded with N-2 so WAIT lasts N-1 cycles and OUT lands at N.
            if ((dec.unit == UNIT_MUL) && (MUL_LAT > 1)) begin
                state_d = ST_WAIT;
                cnt_d   = CNT_W'(MUL_LAT - 2);
            end else if ((dec.unit == UNIT_DIV) && (DIV_LAT > 1)) begin
                state_d = ST_WAIT;
                cnt_d   = CNT_W'(DIV_LAT - 2);
            end else begin
                state_d = ST_OUT;
            end
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        state_d = ST_OUT;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_OUT: begin
                    if (bus.ready_i) begin
                        state_d = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign bus.ready_o         = ready;
    assign bus.valid_o         = (state_q == ST_OUT);
    assign bus.busy_o          = (state_q == ST_WAIT);
    assign bus.alu_operation_o = OP_W'(res_q.op);
    assign bus.unit_sel_o      = res_q.unit;
    assign bus.illegal_o       = res_q.illegal;

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed bench for alu_control_seq: default instance (A), ENABLE_M=0 (B), and
// MUL_LAT=1/DIV_LAT=2 (C), all fed from one shared set of stimulus signals.
module tb_alu_control_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic       valid = 1'b0;
    logic       rdy = 1'b1;
    logic [6:0] f7 = 7'd0;
    logic [2:0] aluOp = 3'd0;
    logic [2:0] f3 = 3'd0;
    int         testCount = 0;
    int         failCount = 0;

    alu_control_seq_if #(.OP_W(4)) busA ();
    alu_control_seq_if #(.OP_W(4)) busB ();
    alu_control_seq_if #(.OP_W(4)) busC ();

    assign busA.flush_i = flush;  assign busA.valid_i = valid;  assign busA.ready_i = rdy;
    assign busA.funct7_i = f7;    assign busA.alu_op_i = aluOp; assign busA.funct3_i = f3;
    assign busB.flush_i = flush;  assign busB.valid_i = valid;  assign busB.ready_i = rdy;
    assign busB.funct7_i = f7;    assign busB.alu_op_i = aluOp; assign busB.funct3_i = f3;
    assign busC.flush_i = flush;  assign busC.valid_i = valid;  assign busC.ready_i = rdy;
    assign busC.funct7_i = f7;    assign busC.alu_op_i = aluOp; assign busC.funct3_i = f3;

    alu_control_seq #(.OP_W(4), .ENABLE_M(1'b1), .MUL_LAT(3), .DIV_LAT(32)) dutA (
        .clk(clk), .reset(reset), .bus(busA.slave));
    alu_control_seq #(.OP_W(4), .ENABLE_M(1'b0), .MUL_LAT(3), .DIV_LAT(32)) dutB (
        .clk(clk), .reset(reset), .bus(busB.slave));
    alu_control_seq #(.OP_W(4), .ENABLE_M(1'b1), .MUL_LAT(1), .DIV_LAT(2)) dutC (
        .clk(clk), .reset(reset), .bus(busC.slave));

    always #5 clk = ~clk;

    // Counts one comparison and reports it when the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Drives the shared selector and valid; takes effect at the next rising edge.
    task automatic applyStimulus(input logic v, input logic [6:0] f7v,
                                 input logic [2:0] aop, input logic [2:0] f3v);
        valid = v;
        f7    = f7v;
        aluOp = aop;
        f3    = f3v;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        flush = 1'b0;
        rdy   = 1'b1;
        applyStimulus(1'b0, 7'd0, 3'd0, 3'd0);
        repeat (2) stepCycle();
        reset = 1'b0;
        #1;
    endtask

    // Offers one op to every instance for a single cycle and checks instance A's result.
    task automatic checkSingleA(input string tag, input logic [6:0] f7v, input logic [2:0] aop,
                                input logic [2:0] f3v, input logic [3:0] expOp,
                                input logic [1:0] expUnit, input logic expIll);
        applyStimulus(1'b1, f7v, aop, f3v);
        stepCycle();
        applyStimulus(1'b0, 7'd0, 3'd0, 3'd0);
        checkOutput({tag, "_valid"}, 32'(busA.valid_o), 32'd1);
        checkOutput({tag, "_op"}, 32'(busA.alu_operation_o), 32'(expOp));
        checkOutput({tag, "_unit"}, 32'(busA.unit_sel_o), 32'(expUnit));
        checkOutput({tag, "_ill"}, 32'(busA.illegal_o), 32'(expIll));
        stepCycle();
    endtask

    logic [3:0] streamOp [4];

    initial begin
        // Reset with a live op on the inputs: it must not be taken.
        reset = 1'b1;
        rdy   = 1'b1;
        applyStimulus(1'b1, 7'b0000000, 3'b000, 3'b000);
        repeat (2) stepCycle();
        applyStimulus(1'b0, 7'd0, 3'd0, 3'd0);
        reset = 1'b0;
        #1;
        checkOutput("rst_valid", 32'(busA.valid_o), 32'd0);
        checkOutput("rst_busy", 32'(busA.busy_o), 32'd0);
        checkOutput("rst_ready", 32'(busA.ready_o), 32'd1);
        checkOutput("rst_op", 32'(busA.alu_operation_o), 32'd0);
        checkOutput("rst_ill", 32'(busA.illegal_o), 32'd0);

        // SRA (R, funct7 alt, funct3 101) -> op 10 one cycle later, then back to idle.
        checkSingleA("sra", 7'b0100000, 3'b000, 3'b101, 4'd10, 2'd0, 1'b0);
        checkOutput("sra_idle", 32'(busA.valid_o), 32'd0);

        // Back-to-back stream: ADD, XOR, SLTI, branch -> 0, 7, 8, 1 on consecutive cycles.
        streamOp = '{4'd0, 4'd7, 4'd8, 4'd1};
        applyStimulus(1'b1, 7'b0000000, 3'b000, 3'b000);
        stepCycle();
        for (int i = 1; i <= 4; i++) begin
            checkOutput($sformatf("stream%0d_valid", i), 32'(busA.valid_o), 32'd1);
            checkOutput($sformatf("stream%0d_op", i), 32'(busA.alu_operation_o),
                        32'(streamOp[i-1]));
            case (i)
                1: applyStimulus(1'b1, 7'b0000000, 3'b000, 3'b100);
                2: applyStimulus(1'b1, 7'b0100000, 3'b001, 3'b010);
                3: applyStimulus(1'b1, 7'b0000000, 3'b011, 3'b111);
                default: applyStimulus(1'b0, 7'd0, 3'd0, 3'd0);
            endcase
            #1;
            if (i < 4) checkOutput($sformatf("stream%0d_ready", i), 32'(busA.ready_o), 32'd1);
            stepCycle();
        end
        checkOutput("stream_end", 32'(busA.valid_o), 32'd0);

        // MUL with MUL_LAT=3: two WAIT cycles then the result.
        applyStimulus(1'b1, 7'b0000001, 3'b000, 3'b000);
        stepCycle();
        applyStimulus(1'b0, 7'd0, 3'd0, 3'd0);
        for (int i = 1; i <= 2; i++) begin
            checkOutput($sformatf("mul_busy%0d", i), 32'(busA.busy_o), 32'd1);
            checkOutput($sformatf("mul_valid%0d", i), 32'(busA.valid_o), 32'd0);
            checkOutput($sformatf("mul_ready%0d", i), 32'(busA.ready_o), 32'd0);
            stepCycle();
        end
        checkOutput("mul_valid", 32'(busA.valid_o), 32'd1);
        checkOutput("mul_op", 32'(busA.alu_operation_o), 32'd11);
        checkOutput("mul_unit", 32'(busA.unit_sel_o), 32'd1);
        checkOutput("mul_busy_end", 32'(busA.busy_o), 32'd0);
        stepCycle();

        // ADDI (funct7 ignored) held for 5 cycles of back-pressure while ORI waits.
        rdy = 1'b0;
        applyStimulus(1'b1, 7'b0100000, 3'b001, 3'b000);
        stepCycle();
        applyStimulus(1'b1, 7'b0000000, 3'b001, 3'b110);
        for (int i = 1; i <= 5; i++) begin
            checkOutput($sformatf("hold%0d_valid", i), 32'(busA.valid_o), 32'd1);
            checkOutput($sformatf("hold%0d_op", i), 32'(busA.alu_operation_o), 32'd0);
            checkOutput($sformatf("hold%0d_ready", i), 32'(busA.ready_o), 32'd0);
            stepCycle();
        end
        rdy = 1'b1;
        #1;
        checkOutput("drain_ready", 32'(busA.ready_o), 32'd1);
        stepCycle();
        applyStimulus(1'b0, 7'd0, 3'd0, 3'd0);
        checkOutput("drain_ori", 32'(busA.alu_operation_o), 32'd2);
        checkOutput("drain_valid", 32'(busA.valid_o), 32'd1);
        stepCycle();
        checkOutput("drain_idle", 32'(busA.valid_o), 32'd0);

        // DIV (DIV_LAT=32) flushed on cycle 10; the ADD offered with the flush is refused.
        applyStimulus(1'b1, 7'b0000001, 3'b000, 3'b100);
        stepCycle();
        applyStimulus(1'b0, 7'd0, 3'd0, 3'd0);
        for (int i = 1; i < 10; i++) begin
            checkOutput($sformatf("div_wait%0d", i), 32'(busA.valid_o), 32'd0);
            stepCycle();
        end
        flush = 1'b1;
        applyStimulus(1'b1, 7'b0000000, 3'b000, 3'b000);
        #1;
        checkOutput("flush_ready", 32'(busA.ready_o), 32'd0);
        stepCycle();
        flush = 1'b0;
        #1;
        checkOutput("flush_busy", 32'(busA.busy_o), 32'd0);
        checkOutput("flush_valid", 32'(busA.valid_o), 32'd0);
        checkOutput("post_flush_ready", 32'(busA.ready_o), 32'd1);
        stepCycle();
        applyStimulus(1'b0, 7'd0, 3'd0, 3'd0);
        checkOutput("post_flush_valid", 32'(busA.valid_o), 32'd1);
        checkOutput("post_flush_op", 32'(busA.alu_operation_o), 32'd0);
        stepCycle();

        // Illegal encodings complete as 1-cycle ops with op 0, unit 0.
        checkSingleA("aluop111", 7'b0000000, 3'b111, 3'b000, 4'd0, 2'd0, 1'b1);
        checkSingleA("r_alt_f3_001", 7'b0100000, 3'b000, 3'b001, 4'd0, 2'd0, 1'b1);
        checkSingleA("slli_alt", 7'b0100000, 3'b001, 3'b001, 4'd0, 2'd0, 1'b1);
        checkSingleA("srai", 7'b0100000, 3'b001, 3'b101, 4'd10, 2'd0, 1'b0);
        checkSingleA("lui", 7'b1111111, 3'b010, 3'b011, 4'd5, 2'd0, 1'b0);
        checkSingleA("mem", 7'b0000000, 3'b100, 3'b010, 4'd0, 2'd0, 1'b0);
        checkSingleA("sltu", 7'b0000000, 3'b000, 3'b011, 4'd9, 2'd0, 1'b0);

        // Reset mid-WAIT aborts the DIV without any output.
        applyStimulus(1'b1, 7'b0000001, 3'b000, 3'b101);
        stepCycle();
        applyStimulus(1'b0, 7'd0, 3'd0, 3'd0);
        repeat (2) stepCycle();
        checkOutput("divu_busy", 32'(busA.busy_o), 32'd1);
        doReset();
        checkOutput("rst_wait_busy", 32'(busA.busy_o), 32'd0);
        checkOutput("rst_wait_valid", 32'(busA.valid_o), 32'd0);
        checkOutput("rst_wait_op", 32'(busA.alu_operation_o), 32'd0);

        // ENABLE_M=0: MUL encoding is illegal and completes in one cycle.
        applyStimulus(1'b1, 7'b0000001, 3'b000, 3'b000);
        stepCycle();
        applyStimulus(1'b0, 7'd0, 3'd0, 3'd0);
        checkOutput("noM_valid", 32'(busB.valid_o), 32'd1);
        checkOutput("noM_ill", 32'(busB.illegal_o), 32'd1);
        checkOutput("noM_op", 32'(busB.alu_operation_o), 32'd0);
        checkOutput("noM_unit", 32'(busB.unit_sel_o), 32'd0);
        doReset();

        // MUL_LAT=1 behaves as a 1-cycle op; DIV_LAT=2 spends one cycle in WAIT.
        applyStimulus(1'b1, 7'b0000001, 3'b000, 3'b001);
        stepCycle();
        applyStimulus(1'b0, 7'd0, 3'd0, 3'd0);
        checkOutput("lat1_valid", 32'(busC.valid_o), 32'd1);
        checkOutput("lat1_op", 32'(busC.alu_operation_o), 32'd12);
        checkOutput("lat1_unit", 32'(busC.unit_sel_o), 32'd1);
        stepCycle();
        applyStimulus(1'b1, 7'b0000001, 3'b000, 3'b110);
        stepCycle();
        applyStimulus(1'b0, 7'd0, 3'd0, 3'd0);
        checkOutput("lat2_busy", 32'(busC.busy_o), 32'd1);
        checkOutput("lat2_wait_valid", 32'(busC.valid_o), 32'd0);
        stepCycle();
        checkOutput("lat2_valid", 32'(busC.valid_o), 32'd1);
        checkOutput("lat2_op", 32'(busC.alu_operation_o), 32'd15);
        checkOutput("lat2_unit", 32'(busC.unit_sel_o), 32'd2);
        stepCycle();

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
